xif_mac_coprocessor: RTL and testbench

- eXtension-interface (CORE-V-XIF subset) coprocessor on the downstream side of the CPU subsystem's issue/commit/result ports.
- Executes custom-0 multiply/accumulate instructions offloaded by the core.
- Buffers accepted instructions in an in-order queue, waits for each commit decision, executes multi-cycle, and returns rd writeback through the result handshake.

---
 rtl/xif_mac_coprocessor_if.sv | 45 ++++
 rtl/xif_mac_coprocessor.sv | 203 ++++++++++++++++++++
 tb/tb_xif_mac_coprocessor.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xif_mac_coprocessor_if.sv
// Issue/commit/result bundle between the core (master) and the MAC coprocessor (slave).
interface xif_mac_coprocessor_if #(
  parameter int unsigned X_ID_WIDTH = 4
);
  logic                  issue_valid;
  logic                  issue_ready;
  logic [31:0]           issue_instr;
  logic [X_ID_WIDTH-1:0] issue_id;
  logic [31:0]           issue_rs0;
  logic [31:0]           issue_rs1;
  logic [1:0]            issue_rs_valid;
  logic                  issue_accept;
  logic                  issue_writeback;

  logic                  commit_valid;
  logic [X_ID_WIDTH-1:0] commit_id;
  logic                  commit_kill;

  logic                  result_valid;
  logic                  result_ready;
  logic [X_ID_WIDTH-1:0] result_id;
  logic [31:0]           result_data;
  logic [4:0]            result_rd;
  logic                  result_we;

  logic                  busy;

  modport master (
    output issue_valid, issue_instr, issue_id, issue_rs0, issue_rs1, issue_rs_valid,
    output commit_valid, commit_id, commit_kill,
    output result_ready,
    input  issue_ready, issue_accept, issue_writeback,
    input  result_valid, result_id, result_data, result_rd, result_we,
    input  busy
  );

  modport slave (
    input  issue_valid, issue_instr, issue_id, issue_rs0, issue_rs1, issue_rs_valid,
    input  commit_valid, commit_id, commit_kill,
    input  result_ready,
    output issue_ready, issue_accept, issue_writeback,
    output result_valid, result_id, result_data, result_rd, result_we,
    output busy
  );
endinterface

// File: rtl/xif_mac_coprocessor.sv
// Custom-0 MUL/MAC/CLR coprocessor: in-order queue of offloaded instructions,
// commit/kill tracking per entry, multi-cycle execute and rd writeback.
module xif_mac_coprocessor #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned LATENCY    = 3,
  parameter int unsigned X_ID_WIDTH = 4
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  xif_mac_coprocessor_if.slave xif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;
  localparam logic [2:0] F3_MUL      = 3'b000;
  localparam logic [2:0] F3_MAC      = 3'b001;
  localparam logic [2:0] F3_CLR      = 3'b010;

  typedef enum logic [1:0] {IDLE, WAIT, EXEC, RESP} state_t;

  function automatic logic is_legal(input logic [31:0] instr);
    return (instr[6:0] == OPC_CUSTOM0) && (instr[31:25] == 7'd0) &&
           (instr[14:12] inside {F3_MUL, F3_MAC, F3_CLR});
  endfunction

  // Returns {new_acc, rd_value}; products and sums wrap modulo 2^32.
  function automatic logic [63:0] exec_op(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] acc_in);
    logic [31:0] prod;
    logic [31:0] sum;
    prod = a * b;
    sum  = acc_in + prod;
    case (op)
      F3_MAC:  return {sum, sum};
      F3_CLR:  return {32'd0, acc_in};
      default: return {acc_in, prod};
    endcase
  endfunction

  logic                  legal;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  lat_en;
  logic                  id_hit_new;
  logic                  unused_bits;

  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count;
  logic [DEPTH-1:0]      ent_vld;
  logic [DEPTH-1:0]      ent_cmt;
  logic [DEPTH-1:0]      ent_kill;
  logic [X_ID_WIDTH-1:0] ent_id [DEPTH];
  logic [2:0]            ent_op [DEPTH];
  logic [4:0]            ent_rd [DEPTH];
  logic [31:0]           ent_a  [DEPTH];
  logic [31:0]           ent_b  [DEPTH];

  state_t                state;
  logic [LAT_W-1:0]      cnt;
  logic [31:0]           acc;
  logic [2:0]            op_p1;
  logic [31:0]           a_p1;
  logic [31:0]           b_p1;
  logic [X_ID_WIDTH-1:0] id_p1;
  logic [4:0]            rd_p1;
  logic [63:0]           op_res;

  logic                  res_valid;
  logic [X_ID_WIDTH-1:0] res_id;
  logic [31:0]           res_data;
  logic [4:0]            res_rd;

  assign unused_bits = ^xif.issue_instr[24:15];

  // Issue decision: ready never looks at issue_valid.
  assign legal      = is_legal(xif.issue_instr);
  assign full       = (count == CNT_W'(DEPTH));
  assign xif.issue_ready = rst_ni && (!legal || (!full && (xif.issue_rs_valid == 2'b11)));
  assign push       = rst_ni && xif.issue_valid && legal && !full && (xif.issue_rs_valid == 2'b11);
  assign xif.issue_accept    = push;
  assign xif.issue_writeback = push;

  assign id_hit_new = xif.commit_valid && (xif.commit_id == xif.issue_id);

  assign lat_en = (state == WAIT) && !ent_kill[head] && ent_cmt[head];
  assign pop    = ((state == WAIT) && ent_kill[head]) || ((state == EXEC) && (cnt == '0));
  assign op_res = exec_op(op_p1, a_p1, b_p1, acc);

  // Queue control: pointers, occupancy and per-entry commit/kill flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      ent_vld  <= '0;
      ent_cmt  <= '0;
      ent_kill <= '0;
    end else begin
      if (xif.commit_valid) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (ent_vld[i] && (ent_id[i] == xif.commit_id)) begin
            if (xif.commit_kill) ent_kill[i] <= 1'b1;
            else                 ent_cmt[i]  <= 1'b1;
          end
        end
      end
      if (pop) begin
        ent_vld[head] <= 1'b0;
        head          <= head + 1'b1;
      end
      if (push) begin
        ent_vld[tail]  <= 1'b1;
        ent_cmt[tail]  <= id_hit_new && !xif.commit_kill;
        ent_kill[tail] <= id_hit_new && xif.commit_kill;
        tail           <= tail + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Queue payload.
  always_ff @(posedge clk_i) begin
    if (push) begin
      ent_id[tail] <= xif.issue_id;
      ent_op[tail] <= xif.issue_instr[14:12];
      ent_rd[tail] <= xif.issue_instr[11:7];
      ent_a[tail]  <= xif.issue_rs0;
      ent_b[tail]  <= xif.issue_rs1;
    end
  end

  // Stage p1: operands of the committed head, held for the whole execute.
  always_ff @(posedge clk_i) begin
    if (lat_en) begin
      op_p1 <= ent_op[head];
      a_p1  <= ent_a[head];
      b_p1  <= ent_b[head];
      id_p1 <= ent_id[head];
      rd_p1 <= ent_rd[head];
    end
  end

  // Head FSM, accumulator and registered result port.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_data  <= '0;
      res_rd    <= '0;
    end else begin
      case (state)
        IDLE: if (ent_vld[head]) state <= WAIT;
        WAIT: begin
          if (ent_kill[head]) begin
            state <= IDLE;
          end else if (ent_cmt[head]) begin
            cnt   <= LAT_W'(LATENCY - 1);
            state <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            acc       <= op_res[63:32];
            res_data  <= op_res[31:0];
            res_id    <= id_p1;
            res_rd    <= rd_p1;
            res_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (xif.result_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign xif.result_valid = res_valid;
  assign xif.result_id    = res_id;
  assign xif.result_data  = res_data;
  assign xif.result_rd    = res_rd;
  assign xif.result_we    = res_valid;
  assign xif.busy         = (count != '0) || (state != IDLE);

endmodule

// File: tb/tb_xif_mac_coprocessor.sv
// Directed bench for xif_mac_coprocessor: stimulus pushes hand-computed results
// into a scoreboard, a negedge monitor pops and compares on each result handshake.
module tb_xif_mac_coprocessor;
  localparam int DEPTH   = 4;
  localparam int LATENCY = 3;
  localparam int IDW     = 4;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [31:0]    data;
    logic [4:0]     rd;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  exp_t sb[$];
  int   checks    = 0;
  int   failures  = 0;
  int   n_results = 0;

  always #5 clk = ~clk;

  xif_mac_coprocessor_if #(.X_ID_WIDTH(IDW)) xif ();

  xif_mac_coprocessor #(.DEPTH(DEPTH), .LATENCY(LATENCY), .X_ID_WIDTH(IDW)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .xif   (xif)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] enc(input logic [2:0] f3, input logic [4:0] rd);
    return {7'b0, 5'd2, 5'd1, f3, rd, 7'b0001011};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && xif.result_valid && xif.result_ready) begin
      n_results++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: id %0d data 0x%0h, none required", xif.result_id, xif.result_data);
      end else begin
        e = sb.pop_front();
        check("res_id",   32'(xif.result_id), 32'(e.id));
        check("res_data", xif.result_data, e.data);
        check("res_rd",   32'(xif.result_rd), 32'(e.rd));
        check("res_we",   32'(xif.result_we), 32'd1);
      end
    end
  end

  task automatic issue(input logic [31:0] instr, input logic [IDW-1:0] id, input logic [31:0] a,
                       input logic [31:0] b, input bit cmt, input bit kl, input bit want,
                       input logic [31:0] exp_data);
    int   k;
    exp_t e;
    @(negedge clk);
    xif.issue_valid    = 1'b1;
    xif.issue_instr    = instr;
    xif.issue_id       = id;
    xif.issue_rs0      = a;
    xif.issue_rs1      = b;
    xif.issue_rs_valid = 2'b11;
    #1;
    k = 0;
    while (!xif.issue_ready && k < 100) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (k >= 100) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout: id %0d ready=%0d after %0d cycles, required 1", id, xif.issue_ready, k);
    end else begin
      xif.commit_valid = cmt;
      xif.commit_id    = id;
      xif.commit_kill  = kl;
      check("issue_accept",    32'(xif.issue_accept), 32'd1);
      check("issue_writeback", 32'(xif.issue_writeback), 32'd1);
      if (want) begin
        e.id   = id;
        e.data = exp_data;
        e.rd   = instr[11:7];
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    xif.issue_valid  = 1'b0;
    xif.commit_valid = 1'b0;
    xif.commit_kill  = 1'b0;
  endtask

  task automatic commit(input logic [IDW-1:0] id, input bit kl);
    @(negedge clk);
    xif.commit_valid = 1'b1;
    xif.commit_id    = id;
    xif.commit_kill  = kl;
    @(posedge clk);
    #1;
    xif.commit_valid = 1'b0;
    xif.commit_kill  = 1'b0;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((sb.size() != 0 || xif.busy) && k < 300) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= 300) begin
      failures++;
      $display("FAIL %s_drain: %0d results outstanding, busy=%0d, required 0/0", name, sb.size(), xif.busy);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  lat;
    int  base;
    int  k;
    logic seen;

    xif.issue_valid    = 1'b0;
    xif.issue_instr    = 32'd0;
    xif.issue_id       = '0;
    xif.issue_rs0      = 32'd0;
    xif.issue_rs1      = 32'd0;
    xif.issue_rs_valid = 2'b00;
    xif.commit_valid   = 1'b0;
    xif.commit_id      = '0;
    xif.commit_kill    = 1'b0;
    xif.result_ready   = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_issue_ready",  32'(xif.issue_ready), 32'd0);
    check("rst_issue_accept", 32'(xif.issue_accept), 32'd0);
    check("rst_result_valid", 32'(xif.result_valid), 32'd0);
    check("rst_result_data",  xif.result_data, 32'd0);
    check("rst_result_we",    32'(xif.result_we), 32'd0);
    check("rst_busy",         32'(xif.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // MUL 7*6, committed at issue, measure latency
    issue(enc(3'b000, 5'd5), 4'd3, 32'd7, 32'd6, 1'b1, 1'b0, 1'b1, 32'd42);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (xif.result_valid) begin
        lat = i;
        break;
      end
    end
    check("mul_latency", 32'(lat), 32'(LATENCY + 2));
    drain("mul");

    // MAC chain with wrap, CLR, then fresh MAC
    issue(enc(3'b001, 5'd10), 4'd0, 32'd2, 32'd3, 1'b1, 1'b0, 1'b1, 32'd6);
    issue(enc(3'b001, 5'd10), 4'd1, 32'd4, 32'd5, 1'b1, 1'b0, 1'b1, 32'd26);
    issue(enc(3'b001, 5'd10), 4'd2, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0, 1'b1, 32'd24);
    issue(enc(3'b010, 5'd11), 4'd3, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 32'd24);
    issue(enc(3'b001, 5'd12), 4'd4, 32'd1, 32'd1, 1'b1, 1'b0, 1'b1, 32'd1);
    drain("mac");

    // Fill the queue with uncommitted MULs
    for (int i = 0; i < DEPTH; i++)
      issue(enc(3'b000, 5'(i + 1)), 4'(i), 32'(i + 1), 32'd10, 1'b0, 1'b0, 1'b1, 32'((i + 1) * 10));
    @(negedge clk);
    xif.issue_valid = 1'b1;
    xif.issue_instr = enc(3'b000, 5'd20);
    xif.issue_id    = 4'd9;
    #1;
    check("full_ready_legal", 32'(xif.issue_ready), 32'd0);
    @(negedge clk);
    xif.issue_instr = enc(3'b011, 5'd20);
    #1;
    check("full_ready_illegal",     32'(xif.issue_ready), 32'd1);
    check("full_accept_illegal",    32'(xif.issue_accept), 32'd0);
    check("full_writeback_illegal", 32'(xif.issue_writeback), 32'd0);
    @(negedge clk);
    xif.issue_valid  = 1'b0;
    xif.issue_instr  = enc(3'b000, 5'd20);
    xif.commit_valid = 1'b1;
    xif.commit_id    = 4'd0;
    @(posedge clk);
    #1;
    xif.commit_valid = 1'b0;
    check("full_ready_before_pop", 32'(xif.issue_ready), 32'd0);
    k = 0;
    while (!xif.issue_ready && k < 30) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("full_ready_after_pop", 32'(xif.issue_ready), 32'd1);
    commit(4'd1, 1'b0);
    commit(4'd2, 1'b0);
    commit(4'd3, 1'b0);
    drain("fill");

    // Kill the middle MAC; accumulator is 1 going in
    base = n_results;
    issue(enc(3'b001, 5'd12), 4'd1, 32'd3, 32'd3, 1'b0, 1'b0, 1'b1, 32'd10);
    issue(enc(3'b001, 5'd13), 4'd2, 32'd100, 32'd100, 1'b0, 1'b0, 1'b0, 32'd0);
    issue(enc(3'b001, 5'd14), 4'd3, 32'd2, 32'd2, 1'b0, 1'b0, 1'b1, 32'd14);
    commit(4'd2, 1'b1);
    commit(4'd1, 1'b0);
    commit(4'd3, 1'b0);
    drain("kill");
    check("kill_result_count", 32'(n_results - base), 32'd2);

    // Result backpressure
    @(posedge clk);
    #1;
    xif.result_ready = 1'b0;
    issue(enc(3'b000, 5'd15), 4'd5, 32'd9, 32'd9, 1'b1, 1'b0, 1'b1, 32'd81);
    issue(enc(3'b000, 5'd16), 4'd6, 32'd3, 32'd4, 1'b1, 1'b0, 1'b1, 32'd12);
    k = 0;
    while (!xif.result_valid && k < 30) begin
      @(negedge clk);
      k++;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(xif.result_valid), 32'd1);
      check("hold_id",    32'(xif.result_id), 32'd5);
      check("hold_data",  xif.result_data, 32'd81);
    end
    @(posedge clk);
    #1;
    xif.result_ready = 1'b1;
    @(posedge clk);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (xif.result_valid) begin
        lat = i;
        break;
      end
    end
    check("hold_next_latency", 32'(lat), 32'(LATENCY + 2));
    drain("hold");

    // Reset while the head is executing with a second entry queued
    issue(enc(3'b000, 5'd17), 4'd7, 32'd5, 32'd5, 1'b1, 1'b0, 1'b0, 32'd0);
    issue(enc(3'b000, 5'd18), 4'd8, 32'd6, 32'd6, 1'b1, 1'b0, 1'b0, 32'd0);
    @(posedge clk);
    #1;
    check("pre_rst_busy", 32'(xif.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_result_valid", 32'(xif.result_valid), 32'd0);
    check("mid_rst_result_data",  xif.result_data, 32'd0);
    check("mid_rst_issue_ready",  32'(xif.issue_ready), 32'd0);
    check("mid_rst_busy",         32'(xif.busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_busy", 32'(xif.busy), 32'd0);
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (xif.result_valid) seen = 1'b1;
    end
    check("post_rst_no_result", 32'(seen), 32'd0);
    check("post_rst_busy_idle", 32'(xif.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
